// File: rtl/dw_reg_array_pkg.sv
// dw_reg_array_pkg: command encodings and defaults shared by the register array and buffer interface
package dw_reg_array_pkg;
  typedef enum logic [1:0] {CMD_IB = 2'b00, CMD_SF = 2'b01, CMD_IF = 2'b10, CMD_NE = 2'b11} cmd_e;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/dw_reg_array_line_fifo.sv
// line_fifo: first-word-fall-through line buffer with occupancy count
module line_fifo
  import dw_reg_array_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DW-1:0]             din,
  output logic [DW-1:0]             dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(FDEPTH):0]   count
);
  localparam int AW = FDEPTH > 1 ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH) + 1;
  logic [DW-1:0] r_mem [FDEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_pop, w_push;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FDEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = r_cnt == CW'(FDEPTH);
  assign empty = r_cnt == '0;
  assign count = r_cnt;
  assign dout = r_mem[r_rp];
  assign w_pop = pop & ~empty;
  // a full FIFO still accepts a push when the same cycle frees a slot
  assign w_push = push & (~full | w_pop);
  always_ff @(posedge clk)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wp] <= din;
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/dw_reg_array.sv
// dw_reg_array: per-row window shift registers fed from the input buffer or line FIFOs
module dw_reg_array
  import dw_reg_array_pkg::*;
#(
  parameter int POY = 3,
  parameter int KSIZE = 3,
  parameter int DW = DW_DEF,
  parameter int FDEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    reg_array_cmd [POY],
  input  logic [DW-1:0] buf_pix [POY],
  input  logic          fifo_read,
  input  logic          dwpe_ena,
  output logic [DW-1:0] win [POY][KSIZE],
  output logic          win_vld,
  output logic          fifo_ovf,
  output logic          fifo_udf
);
  localparam int CW = $clog2(FDEPTH) + 1;
  logic [DW-1:0] r_sr [POY][KSIZE];
  logic [DW-1:0] r_stage [POY-1];
  logic [DW-1:0] w_in [POY];
  logic [DW-1:0] w_dout [POY-1];
  logic [CW-1:0] w_count [POY-1];
  logic [POY-2:0] w_push, w_full, w_empty, w_ovf, w_udf;
  logic r_vld, r_ovf, r_udf;
  for (genvar j = 0; j < POY - 1; j++) begin : g_fifo
    assign w_push[j] = reg_array_cmd[j+1] == CMD_IB;
    assign w_ovf[j] = w_push[j] & w_full[j] & ~fifo_read;
    assign w_udf[j] = fifo_read & (w_count[j] == '0);
    line_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(w_push[j]), .pop(fifo_read), .din(buf_pix[j+1]),
      .dout(w_dout[j]), .full(w_full[j]), .empty(w_empty[j]), .count(w_count[j])
    );
  end
  for (genvar i = 0; i < POY; i++) begin : g_row
    // the bottom row has no FIFO below it, so IF still takes the buffer pixel
    if (i < POY - 1) begin : g_mid
      assign w_in[i] = reg_array_cmd[i] == CMD_IF ? r_stage[i] : buf_pix[i];
    end else begin : g_last
      assign w_in[i] = buf_pix[i];
    end
    for (genvar k = 0; k < KSIZE; k++) begin : g_win
      assign win[i][k] = r_sr[i][k];
    end
  end
  assign win_vld = r_vld;
  assign fifo_ovf = r_ovf;
  assign fifo_udf = r_udf;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < POY; i++)
        for (int k = 0; k < KSIZE; k++) r_sr[i][k] <= '0;
      for (int j = 0; j < POY - 1; j++) r_stage[j] <= '0;
      r_vld <= 1'b0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      for (int i = 0; i < POY; i++)
        if (reg_array_cmd[i] != CMD_NE) begin
          for (int k = 0; k < KSIZE - 1; k++) r_sr[i][k] <= r_sr[i][k+1];
          r_sr[i][KSIZE-1] <= w_in[i];
        end
      for (int j = 0; j < POY - 1; j++)
        if (fifo_read && !w_empty[j]) r_stage[j] <= w_dout[j];
      r_vld <= dwpe_ena;
      r_ovf <= r_ovf | (|w_ovf);
      r_udf <= r_udf | (|w_udf);
    end
endmodule

// File: tb/tb_dw_reg_array.sv
// tb_dw_reg_array: directed and randomized checks against a queue-based reference model
module tb_dw_reg_array;
  localparam logic [5:0] ALL_IB = 6'b000000;
  localparam logic [5:0] ALL_NE = 6'b111111;
  localparam logic [5:0] ALL_IF = 6'b101010;
  logic clk, rst, fifo_read, dwpe_ena, win_vld, fifo_ovf, fifo_udf;
  logic [1:0] cmd [3];
  logic [7:0] pix [3];
  logic [7:0] win [3][3];
  logic [7:0] m_win [3][3];
  logic [7:0] m_stage [3];
  logic [7:0] m_q [2][$];
  logic m_ovf, m_udf, m_vld;
  int checks = 0, failures = 0;

  dw_reg_array #(.POY(3), .KSIZE(3), .DW(8), .FDEPTH(8)) dut (
    .clk(clk), .rst(rst), .reg_array_cmd(cmd), .buf_pix(pix), .fifo_read(fifo_read),
    .dwpe_ena(dwpe_ena), .win(win), .win_vld(win_vld), .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick(input logic [5:0] cv, input logic [23:0] pv, input logic rd, input logic en);
    logic [7:0] nin [3];
    for (int i = 0; i < 3; i++) begin
      cmd[i] = cv[2*i +: 2];
      pix[i] = pv[8*i +: 8];
    end
    fifo_read = rd;
    dwpe_ena = en;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_stage[i] = 0;
        for (int k = 0; k < 3; k++) m_win[i][k] = 0;
      end
      m_q[0].delete();
      m_q[1].delete();
      m_ovf = 0; m_udf = 0; m_vld = 0;
    end else begin
      for (int i = 0; i < 3; i++) nin[i] = (cmd[i] == 2'b10 && i < 2) ? m_stage[i] : pix[i];
      for (int i = 0; i < 3; i++)
        if (cmd[i] != 2'b11) begin
          m_win[i][0] = m_win[i][1];
          m_win[i][1] = m_win[i][2];
          m_win[i][2] = nin[i];
        end
      for (int j = 0; j < 2; j++) begin
        if (rd) begin
          if (m_q[j].size() == 0) m_udf = 1;
          else m_stage[j] = m_q[j].pop_front();
        end
        if (cmd[j+1] == 2'b00) begin
          if (m_q[j].size() == 8) m_ovf = 1;
          else m_q[j].push_back(pix[j+1]);
        end
      end
      m_vld = en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(ALL_NE, 24'h0, 0, 0);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (win[i][k] !== 8'd0) begin failures++; $display("FAIL reset_win[%0d][%0d] got=%0d exp=0", i, k, win[i][k]); end
      end
    checks++;
    if ({win_vld, fifo_ovf, fifo_udf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {win_vld, fifo_ovf, fifo_udf}); end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (dut.w_count[j] !== 4'd0) begin failures++; $display("FAIL reset_count[%0d] got=%0d exp=0", j, dut.w_count[j]); end
    end
  endtask

  task automatic test_ib_fill();
    int exp [3][3];
    exp = '{'{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9}};
    tick(ALL_IB, {8'd3, 8'd2, 8'd1}, 0, 0);
    tick(ALL_IB, {8'd6, 8'd5, 8'd4}, 0, 0);
    tick(ALL_IB, {8'd9, 8'd8, 8'd7}, 0, 0);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (win[i][k] !== 8'(exp[i][k])) begin failures++; $display("FAIL ib_win[%0d][%0d] got=%0d exp=%0d", i, k, win[i][k], exp[i][k]); end
      end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (dut.w_count[j] !== 4'd3) begin failures++; $display("FAIL ib_count[%0d] got=%0d exp=3", j, dut.w_count[j]); end
    end
  endtask

  task automatic test_if();
    int exp [3][3];
    exp = '{'{4, 7, 2}, '{5, 8, 3}, '{6, 9, 10}};
    tick(ALL_NE, 24'h0, 1, 0);
    checks++;
    if ({dut.r_stage[0], dut.r_stage[1]} !== {8'd2, 8'd3}) begin
      failures++; $display("FAIL if_stage got=%0d,%0d exp=2,3", dut.r_stage[0], dut.r_stage[1]);
    end
    tick(ALL_IF, {8'd10, 8'd0, 8'd0}, 0, 0);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (win[i][k] !== 8'(exp[i][k])) begin failures++; $display("FAIL if_win[%0d][%0d] got=%0d exp=%0d", i, k, win[i][k], exp[i][k]); end
      end
    checks++;
    if ({dut.w_count[0], dut.w_count[1], fifo_udf} !== {4'd2, 4'd2, 1'b0}) begin
      failures++; $display("FAIL if_count got=%0d,%0d udf=%b exp=2,2 udf=0", dut.w_count[0], dut.w_count[1], fifo_udf);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 0; n < 9; n++) begin
      tick(ALL_IB, 24'($urandom), 0, 0);
      if (n == 7) begin
        checks++;
        if ({dut.w_count[0], fifo_ovf} !== {4'd8, 1'b0}) begin failures++; $display("FAIL ovf_at8 count=%0d ovf=%b exp=8 ovf=0", dut.w_count[0], fifo_ovf); end
      end
    end
    checks++;
    if ({dut.w_count[0], dut.w_count[1], fifo_ovf} !== {4'd8, 4'd8, 1'b1}) begin
      failures++; $display("FAIL ovf_at9 count=%0d,%0d ovf=%b exp=8,8 ovf=1", dut.w_count[0], dut.w_count[1], fifo_ovf);
    end
    tick(ALL_IB, 24'($urandom), 1, 0);
    checks++;
    if ({dut.w_count[0], dut.w_count[1], fifo_udf} !== {4'd8, 4'd8, 1'b0}) begin
      failures++; $display("FAIL ovf_pushpop count=%0d,%0d udf=%b exp=8,8 udf=0", dut.w_count[0], dut.w_count[1], fifo_udf);
    end
    checks++;
    if ({dut.r_stage[0], dut.r_stage[1]} !== {m_stage[0], m_stage[1]}) begin
      failures++; $display("FAIL ovf_stage got=%0d,%0d exp=%0d,%0d", dut.r_stage[0], dut.r_stage[1], m_stage[0], m_stage[1]);
    end
  endtask

  task automatic test_underflow_vld();
    do_reset();
    tick(ALL_NE, 24'h0, 1, 0);
    checks++;
    if ({fifo_udf, dut.r_stage[0], dut.r_stage[1], win_vld} !== {1'b1, 16'h0, 1'b0}) begin
      failures++; $display("FAIL udf got udf=%b stage=%0d,%0d vld=%b exp udf=1 stage=0,0 vld=0", fifo_udf, dut.r_stage[0], dut.r_stage[1], win_vld);
    end
    for (int n = 0; n < 6; n++) begin
      tick(ALL_NE, 24'h0, 0, n < 4);
      checks++;
      if (win_vld !== (n < 4)) begin failures++; $display("FAIL vld_cycle%0d got=%b exp=%b", n, win_vld, n < 4); end
    end
  endtask

  task automatic test_mid_reset();
    tick(ALL_NE, 24'h0, 1, 0);
    for (int n = 0; n < 5; n++) tick(ALL_IB, 24'($urandom), 0, 1);
    checks++;
    if ({dut.w_count[0], fifo_udf} !== {4'd5, 1'b1}) begin failures++; $display("FAIL mid_pre count=%0d udf=%b exp=5 udf=1", dut.w_count[0], fifo_udf); end
    rst = 1;
    tick(ALL_IB, 24'hABCDEF, 1, 1);
    rst = 0;
    checks++;
    if ({dut.w_count[0], dut.w_count[1], win_vld, fifo_ovf, fifo_udf} !== 11'h0) begin
      failures++; $display("FAIL mid_rst count=%0d,%0d vld=%b ovf=%b udf=%b exp all 0", dut.w_count[0], dut.w_count[1], win_vld, fifo_ovf, fifo_udf);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({win[i][0], win[i][1], win[i][2]} !== 24'h0) begin failures++; $display("FAIL mid_rst_win[%0d] got=%h exp=0", i, {win[i][0], win[i][1], win[i][2]}); end
    end
    tick(ALL_IB, {8'd13, 8'd12, 8'd11}, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({win[i][0], win[i][1], win[i][2]} !== {16'h0, 8'(11 + i)}) begin
        failures++; $display("FAIL mid_load_win[%0d] got=%h exp=%h", i, {win[i][0], win[i][1], win[i][2]}, {16'h0, 8'(11 + i)});
      end
    end
    checks++;
    if (dut.w_count[0] !== 4'd1) begin failures++; $display("FAIL mid_load_count got=%0d exp=1", dut.w_count[0]); end
  endtask

  task automatic test_random();
    logic rd;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 99) == 0;
      rd = n < 200 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 1) == 0;
      tick(6'($urandom), 24'($urandom), rd, 1'($urandom));
      rst = 0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({win[i][0], win[i][1], win[i][2]} !== {m_win[i][0], m_win[i][1], m_win[i][2]}) begin
          failures++; $display("FAIL rnd%0d_win[%0d] got=%h exp=%h", n, i, {win[i][0], win[i][1], win[i][2]}, {m_win[i][0], m_win[i][1], m_win[i][2]});
        end
      end
      checks++;
      if ({win_vld, fifo_ovf, fifo_udf} !== {m_vld, m_ovf, m_udf}) begin
        failures++; $display("FAIL rnd%0d_flags got=%b exp=%b", n, {win_vld, fifo_ovf, fifo_udf}, {m_vld, m_ovf, m_udf});
      end
      for (int j = 0; j < 2; j++) begin
        checks++;
        if ({dut.w_count[j], dut.r_stage[j]} !== {4'(m_q[j].size()), m_stage[j]}) begin
          failures++; $display("FAIL rnd%0d_fifo[%0d] count=%0d stage=%0d exp count=%0d stage=%0d", n, j, dut.w_count[j], dut.r_stage[j], m_q[j].size(), m_stage[j]);
        end
      end
    end
  endtask

  initial begin
    rst = 0; fifo_read = 0; dwpe_ena = 0;
    for (int i = 0; i < 3; i++) begin cmd[i] = 2'b11; pix[i] = 0; end
    #2;
    test_reset();
    test_ib_fill();
    test_if();
    test_overflow();
    test_underflow_vld();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dw_reg_array.md
DW_REG_ARRAY -- requirements
Module: dw_reg_array

Interface
REQ-001 SHALL expose parameters: POY, default 3, output rows; KSIZE, default 3, window width; DW, default 8, pixel width; FDEPTH, default 8, line-FIFO depth per row.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: reg_array_cmd[POY]  in  2 each  per-row command: IB=00, SF=01, IF=10, NE=11.
REQ-005 SHALL have port: buf_pix[POY]  in  DW each  pixel column from the input buffer, valid whenever the command is IB or SF, and for row POY-1 under IF.
REQ-006 SHALL have port: fifo_read  in  1  single-cycle pulse that pops each line FIFO head into that row's staging register.
REQ-007 SHALL have port: dwpe_ena  in  1  compute enable from the buffer interface.
REQ-008 SHALL have port: win[POY][KSIZE]  out  DW each  current window; win[i][0] is the oldest pixel.
REQ-009 SHALL have port: win_vld  out  1  window valid to the DWPE.
REQ-010 SHALL have port: fifo_ovf  out  1  sticky overflow flag.
REQ-011 SHALL have port: fifo_udf  out  1  sticky underflow flag.

Function
REQ-012 SHALL keep, per row i, a KSIZE-stage shift register sr[i] with win[i][k]=sr[i][k], driven from registers.
REQ-013 IB, row i: SHALL shift sr[i][k]<=sr[i][k+1] and load sr[i][KSIZE-1]<=buf_pix[i]; for i>=1, SHALL also push buf_pix[i] into line FIFO i-1.
REQ-014 SF, row i: SHALL perform the same shift-in from buf_pix[i] with no FIFO push.
REQ-015 IF, row i<POY-1: SHALL shift in stage[i]; row POY-1 under IF SHALL shift in buf_pix[POY-1] with no push.
REQ-016 NE: SHALL hold sr[i] unchanged.
REQ-017 Rows SHALL be decoded independently; mixed commands in one cycle are legal.
REQ-018 SHALL have POY-1 line FIFOs, each DW wide and FDEPTH deep, first-word-fall-through, with a count of width clog2(FDEPTH)+1.
REQ-019 fifo_read SHALL pop every non-empty FIFO and register its head into stage[i] one cycle later; stage[i] SHALL hold between pops.
REQ-020 Push to a full FIFO SHALL be dropped and SHALL set fifo_ovf, unless a pop of the same FIFO occurs in the same cycle; in that case both SHALL occur and the count SHALL stay unchanged.
REQ-021 fifo_read on an empty FIFO SHALL leave that stage unchanged and SHALL set fifo_udf.
REQ-022 Simultaneous push and pop on an empty FIFO SHALL count as underflow; the push SHALL still complete (count becomes 1).
REQ-023 win_vld SHALL equal dwpe_ena delayed by exactly one cycle, aligned with the sr update made in the same cycle as dwpe_ena.
REQ-024 Sticky flags SHALL clear only on reset.
REQ-025 Read and write pointers SHALL wrap modulo FDEPTH.

Reset
REQ-026 On rst=1, on the next edge: all sr and stage registers SHALL be 0, FIFO pointers and counts 0, win_vld 0, fifo_ovf 0, fifo_udf 0.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents and in-flight pops; reset SHALL override every command in that cycle.

Structure
REQ-028 The cmd encodings IB/SF/IF/NE and the default DW SHALL live in a shared package, also used by the buffer interface.
REQ-029 The line FIFO SHALL be the single sub-module line_fifo (parameters DW, FDEPTH; ports push, pop, din, dout, full, empty, count), instantiated POY-1 times.

Verification (POY=3, KSIZE=3, DW=8, FDEPTH=8)
REQ-030 Three IB cycles with buf_pix={1,2,3},{4,5,6},{7,8,9} -> win[0]={1,4,7}, win[1]={2,5,8}, win[2]={3,6,9}; FIFO0 holds 2,5,8 and FIFO1 holds 3,6,9.
REQ-031 After REQ-030, send fifo_read, then IF with buf_pix[2]=10 -> stage={2,3}; win[0]={4,7,2}, win[1]={5,8,3}, win[2]={6,9,10}.
REQ-032 Nine IB pushes with no pop -> count=8 and fifo_ovf=1 after the ninth; a subsequent push+pop on the full FIFO -> count stays 8 and no further error.
REQ-033 fifo_read after reset -> fifo_udf=1 and stage=0; dwpe_ena high for 4 cycles -> win_vld high for 4 cycles, starting one cycle later.
REQ-034 rst pulsed mid-stream with count=5 -> next cycle count=0, win all 0, flags 0; a following IB loads normally.
